// File: rtl/led_display_row_sequencer.sv
// Row scan sequencer for a HUB75-style LED panel: fetches a row pair, hands it to the
// shift PHY, then blanks, latches and holds it lit while the next row is prepared.
module led_display_row_sequencer #(
  parameter int unsigned NUM_COLS     = 64,
  parameter int unsigned NUM_ROWS     = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES  = 256
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  output logic                  rd_en_out,
  output logic [ADDR_W-1:0]     rd_addr_out,
  input  logic [3*NUM_COLS-1:0] rd_top_in,
  input  logic [3*NUM_COLS-1:0] rd_bot_in,
  output logic [3*NUM_COLS-1:0] col_top_out,
  output logic [3*NUM_COLS-1:0] col_bot_out,
  output logic                  phy_enable_out,
  input  logic                  phy_ready_in,
  output logic [ADDR_W-1:0]     addr_out,
  output logic                  le_out,
  output logic                  oe_out,
  output logic                  frame_done_out
);

  localparam int unsigned CntMax = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]   HoldLast  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]   BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);
  localparam logic [ADDR_W-1:0] RowLast   = ADDR_W'(NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] RowOne    = ADDR_W'(1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StStart, StWait, StBlank, StLatch, StShow
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     row_q, row_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  lit_q, lit_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  done_q, done_d;
  logic [3*NUM_COLS-1:0] col_top_q, col_bot_q;
  logic                  load_cols;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= StIdle;
      row_q     <= '0;
      cnt_q     <= '0;
      lit_q     <= 1'b0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      col_top_q <= '0;
      col_bot_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      lit_q   <= lit_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      if (load_cols) begin
        col_top_q <= rd_top_in;
        col_bot_q <= rd_bot_in;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    cnt_d          = cnt_q;
    lit_d          = lit_q;
    addr_d         = addr_q;
    done_d         = 1'b0;
    load_cols      = 1'b0;
    rd_en_out      = 1'b0;
    phy_enable_out = 1'b0;
    le_out         = 1'b0;
    oe_out         = 1'b1;

    unique case (state_q)
      StIdle: begin
        row_d = '0;
        lit_d = 1'b0;
        if (enable_in) state_d = StFetch;
      end
      StFetch: begin
        rd_en_out = 1'b1;
        oe_out    = ~lit_q;
        state_d   = StLoad;
      end
      StLoad: begin
        load_cols = 1'b1;
        oe_out    = ~lit_q;
        state_d   = StStart;
      end
      StStart: begin
        phy_enable_out = 1'b1;
        oe_out         = ~lit_q;
        cnt_d          = '0;
        state_d        = StWait;
      end
      StWait: begin
        oe_out = ~lit_q;
        // The PHY may still report ready on the cycle after the start pulse, so the
        // first WAIT cycle never exits; WAIT always spans at least two cycles.
        if (cnt_q != '0 && phy_ready_in) begin
          cnt_d   = '0;
          addr_d  = row_q;
          state_d = StBlank;
        end else begin
          cnt_d = CntOne;
        end
      end
      StBlank: begin
        if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          state_d = StLatch;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLatch: begin
        le_out  = 1'b1;
        lit_d   = 1'b1;
        cnt_d   = '0;
        state_d = StShow;
      end
      StShow: begin
        oe_out = 1'b0;
        if (cnt_q == HoldLast) begin
          cnt_d  = '0;
          done_d = (row_q == RowLast);
          row_d  = (row_q == RowLast) ? '0 : row_q + RowOne;
          if (enable_in) begin
            state_d = StFetch;
          end else begin
            state_d = StIdle;
            lit_d   = 1'b0;
            row_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_addr_out    = row_q;
  assign col_top_out    = col_top_q;
  assign col_bot_out    = col_bot_q;
  assign addr_out       = addr_q;
  assign frame_done_out = done_q;

endmodule
